// File: rtl/flash_burst_ctl.sv
// rtl/flash_burst_ctl.sv - SPI NOR burst read / program-and-poll controller
module flash_burst_ctl #(
    parameter int ADDR_BYTES = 3,
    parameter int DATA_BYTES = 4,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2,
    parameter int POLL_MAX   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [8*ADDR_BYTES-1:0] req_addr,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    spi_clk,
    output logic                    spi_cs_n,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);
    localparam int AW   = 8 * ADDR_BYTES;
    localparam int DW   = 8 * DATA_BYTES;
    localparam int FW   = 8 * (1 + ADDR_BYTES + DATA_BYTES);
    localparam int BW   = $clog2(FW + 1);
    localparam int DIVW = $clog2(CLK_DIV + 1);
    localparam int GAPW = $clog2(CS_GAP + 1);
    localparam int PW0  = $clog2(POLL_MAX + 1);
    localparam int PW   = (PW0 > 11) ? PW0 : 11;

    typedef enum logic [2:0] {IDLE, READ, WREN, GAP, PROG, POLL, DONE} state_t;

    state_t          state;
    state_t          gap_next;
    logic [GAPW-1:0] gap_cnt;
    logic [DIVW-1:0] div_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [FW-1:0]   tx;
    logic [DW-1:0]   rx;
    logic [DW-1:0]   rx_next;
    logic [PW-1:0]   poll_cnt;
    logic            in_frame;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   res_rdata;
    logic            res_err;
    logic [FW-1:0]   frame_load;
    logic [BW-1:0]   frame_last;

    // Frame image (left-aligned, MSB first) and index of its last bit for the current frame state
    always_comb begin
        frame_load = '0;
        frame_last = BW'(FW - 1);
        rx_next    = {rx[DW-2:0], spi_miso};
        case (state)
            READ: frame_load = {8'h03, addr_q, {DW{1'b0}}};
            WREN: begin
                frame_load = {8'h06, {(FW-8){1'b0}}};
                frame_last = BW'(7);
            end
            PROG: frame_load = {8'h02, addr_q, wdata_q};
            POLL: begin
                frame_load = {8'h05, {(FW-8){1'b0}}};
                frame_last = BW'(15);
            end
            default: ;
        endcase
    end

    // Sequencer, SCK divider and shifter; a completing frame decides the next state on its final edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= GAP;
            gap_next  <= IDLE;
            gap_cnt   <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            poll_cnt  <= '0;
            in_frame  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            res_rdata <= '0;
            res_err   <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            spi_clk   <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (rsp_valid) busy <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        poll_cnt  <= '0;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= req_write ? WREN : READ;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAPW'(CS_GAP - 1)) begin
                        gap_cnt <= '0;
                        state   <= gap_next;
                        if (gap_next == IDLE) req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= res_rdata;
                    rsp_err   <= res_err;
                    state     <= GAP;
                    gap_next  <= IDLE;
                end
                default: begin
                    if (!in_frame) begin
                        in_frame <= 1'b1;
                        spi_cs_n <= 1'b0;
                        spi_clk  <= 1'b0;
                        tx       <= frame_load;
                        spi_mosi <= frame_load[FW-1];
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                    end else if (div_cnt != DIVW'(CLK_DIV - 1)) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                        end else begin
                            spi_clk <= 1'b0;
                            rx      <= rx_next;
                            if (bit_cnt == frame_last) begin
                                in_frame <= 1'b0;
                                spi_cs_n <= 1'b1;
                                spi_mosi <= 1'b0;
                                case (state)
                                    READ: begin
                                        res_rdata <= rx_next;
                                        res_err   <= 1'b0;
                                        state     <= DONE;
                                    end
                                    WREN: begin
                                        state    <= GAP;
                                        gap_next <= PROG;
                                    end
                                    PROG: begin
                                        state    <= GAP;
                                        gap_next <= POLL;
                                    end
                                    default: begin
                                        // The final sampled bit is WIP (status bit 0)
                                        poll_cnt <= poll_cnt + 1'b1;
                                        if (!spi_miso) begin
                                            res_rdata <= '0;
                                            res_err   <= 1'b0;
                                            state     <= DONE;
                                        end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                                            res_rdata <= '0;
                                            res_err   <= 1'b1;
                                            state     <= DONE;
                                        end else begin
                                            state    <= GAP;
                                            gap_next <= POLL;
                                        end
                                    end
                                endcase
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                tx       <= {tx[FW-2:0], 1'b0};
                                spi_mosi <= tx[FW-2];
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule
